// File: rtl/iir_biquad_tdm.sv
// Multi-channel cascaded direct-form-I biquad IIR filter sharing one MAC across all
// (channel, section) pairs; coefficients per section are shared by every channel.
module iir_biquad_tdm #(
    parameter int CHANNELS = 2,
    parameter int SECTIONS = 2,
    parameter int DW       = 16,
    parameter int CW       = 24,
    parameter int CFRAC    = 21,
    parameter int AW       = 48
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DW-1:0]        in_data,
    output logic                          out_valid,
    output logic [CHANNELS*DW-1:0]        out_data,
    input  logic                          coef_we,
    output logic                          coef_ready,
    input  logic [$clog2(SECTIONS)+2:0]   coef_addr,
    input  logic signed [CW-1:0]          coef_wdata,
    input  logic                          state_clr
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SCW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);
    localparam logic [SCW-1:0] SEC_LAST = SCW'(SECTIONS - 1);
    localparam logic signed [AW-1:0] ACC_RND  = AW'(1) << (CFRAC - 1);
    localparam logic signed [CW-1:0] COEF_ONE = CW'(1) << CFRAC;
    localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t               state;
    logic [CHW-1:0]       ch;
    logic [SCW-1:0]       sec;
    logic [2:0]           k;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] cur_x;
    logic                 clr_pend;

    logic signed [CW-1:0] coef  [SECTIONS][5];
    logic signed [DW-1:0] x1    [CHANNELS][SECTIONS];
    logic signed [DW-1:0] x2    [CHANNELS][SECTIONS];
    logic signed [DW-1:0] y1    [CHANNELS][SECTIONS];
    logic signed [DW-1:0] y2    [CHANNELS][SECTIONS];
    logic signed [DW-1:0] frame [CHANNELS];
    logic signed [DW-1:0] res   [CHANNELS];

    logic signed [CW-1:0]    c_op;
    logic signed [DW-1:0]    d_op;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_next;
    logic signed [AW-1:0]    acc_sh;
    logic signed [DW-1:0]    r;
    logic                    clr_now;
    int                      cw_sec;
    logic [2:0]              cw_idx;

    assign in_ready   = (state == IDLE);
    assign coef_ready = in_ready;
    assign cw_sec     = int'(coef_addr >> 3);
    assign cw_idx     = coef_addr[2:0];
    assign clr_now    = (state == IDLE && state_clr) || (state == DONE && (clr_pend || state_clr));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        c_op = '0;
        d_op = '0;
        case (k)
            3'd0:    begin c_op = coef[sec][0]; d_op = cur_x;        end
            3'd1:    begin c_op = coef[sec][1]; d_op = x1[ch][sec];  end
            3'd2:    begin c_op = coef[sec][2]; d_op = x2[ch][sec];  end
            3'd3:    begin c_op = coef[sec][3]; d_op = y1[ch][sec];  end
            3'd4:    begin c_op = coef[sec][4]; d_op = y2[ch][sec];  end
            default: ;
        endcase
        prod     = (DW+CW)'(c_op) * (DW+CW)'(d_op);
        acc_next = (k >= 3'd3) ? acc - AW'(prod) : acc + AW'(prod);
        acc_sh   = acc >>> CFRAC;
        if (acc_sh > SAT_MAX)      r = SAT_MAX[DW-1:0];
        else if (acc_sh < SAT_MIN) r = SAT_MIN[DW-1:0];
        else                       r = acc_sh[DW-1:0];
    end

    // NOTE: history is a small register file that must start from silence, so it is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < SECTIONS; s++) begin
                    x1[c][s] <= '0; x2[c][s] <= '0; y1[c][s] <= '0; y2[c][s] <= '0;
                end
        end else if (clr_now) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < SECTIONS; s++) begin
                    x1[c][s] <= '0; x2[c][s] <= '0; y1[c][s] <= '0; y2[c][s] <= '0;
                end
        end else if (state == WB) begin
            x2[ch][sec] <= x1[ch][sec];
            x1[ch][sec] <= cur_x;
            y2[ch][sec] <= y1[ch][sec];
            y1[ch][sec] <= r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SECTIONS; s++)
                for (int i = 0; i < 5; i++)
                    coef[s][i] <= (i == 0) ? COEF_ONE : '0;
        end else if (coef_we && in_ready) begin
            for (int s = 0; s < SECTIONS; s++)
                for (int i = 0; i < 5; i++)
                    if (cw_sec == s && cw_idx == 3'(i)) coef[s][i] <= coef_wdata;
        end
    end

    // Sequencer: each (ch, sec) takes five MAC cycles plus one write-back cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            sec       <= '0;
            k         <= '0;
            acc       <= '0;
            cur_x     <= '0;
            clr_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                frame[c] <= '0;
                res[c]   <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (state != IDLE && state_clr) clr_pend <= 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    for (int c = 0; c < CHANNELS; c++) frame[c] <= in_data[c*DW +: DW];
                    cur_x <= in_data[DW-1:0];
                    ch    <= '0;
                    sec   <= '0;
                    k     <= '0;
                    acc   <= ACC_RND;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (k == 3'd4) begin
                        k     <= '0;
                        state <= WB;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                WB: begin
                    acc   <= ACC_RND;
                    state <= MAC;
                    if (sec == SEC_LAST) begin
                        res[ch] <= r;
                        sec     <= '0;
                        if (ch == CH_LAST) begin
                            state <= DONE;
                        end else begin
                            ch    <= ch + 1'b1;
                            cur_x <= frame[ch + 1'b1];
                        end
                    end else begin
                        sec   <= sec + 1'b1;
                        cur_x <= r;
                    end
                end
                DONE: begin
                    for (int c = 0; c < CHANNELS; c++) out_data[c*DW +: DW] <= res[c];
                    out_valid <= 1'b1;
                    clr_pend  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Randomized and directed bench for iir_biquad_tdm against a plain-arithmetic biquad model.
module tb_iir_biquad_tdm;

    localparam int CH = 2;
    localparam int SEC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        coef_we;
    logic        coef_ready;
    logic [3:0]  coef_addr;
    logic [23:0] coef_wdata;
    logic        state_clr;

    int n_checks = 0;
    int n_errors = 0;

    longint mc  [SEC][5];
    longint mx1 [CH][SEC];
    longint mx2 [CH][SEC];
    longint my1 [CH][SEC];
    longint my2 [CH][SEC];

    iir_biquad_tdm dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .coef_we(coef_we), .coef_ready(coef_ready),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .state_clr(state_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] caddr(input int s, input int i);
        return {1'(s), 3'(i)};
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < SEC; s++) begin
                mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
            end
    endtask

    task automatic model_reset();
        model_clear();
        for (int s = 0; s < SEC; s++)
            for (int i = 0; i < 5; i++) mc[s][i] = (i == 0) ? (64'sd1 <<< 21) : 0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [23:0] v);
        if (a[2:0] < 3'd5) mc[a[3]][a[2:0]] = longint'(signed'(v));
    endtask

    // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half up, saturated to 16 bits
    task automatic model_frame(input logic [31:0] din, output logic [31:0] dout);
        for (int c = 0; c < CH; c++) begin
            longint x;
            x = longint'(signed'(din[c*16 +: 16]));
            for (int s = 0; s < SEC; s++) begin
                longint acc;
                longint r;
                acc = (64'sd1 <<< 20) + mc[s][0] * x + mc[s][1] * mx1[c][s] + mc[s][2] * mx2[c][s]
                      - mc[s][3] * my1[c][s] - mc[s][4] * my2[c][s];
                r = sat16(acc >>> 21);
                mx2[c][s] = mx1[c][s]; mx1[c][s] = x;
                my2[c][s] = my1[c][s]; my1[c][s] = r;
                x = r;
            end
            dout[c*16 +: 16] = 16'(x);
        end
    endtask

    task automatic write_coef(input int s, input int i, input logic [23:0] v);
        coef_we = 1'b1; coef_addr = caddr(s, i); coef_wdata = v;
        @(posedge clk); #1;
        coef_we = 1'b0;
        model_write(caddr(s, i), v);
    endtask

    task automatic clr_idle();
        state_clr = 1'b1;
        @(posedge clk); #1;
        state_clr = 1'b0;
        model_clear();
    endtask

    task automatic run_frame(input logic [31:0] din, input bit clr_acc, input bit clr_mid,
                             input bit coef_acc, input bit coef_mid, input logic [3:0] ca,
                             input logic [23:0] cd, output logic [31:0] got);
        logic [31:0] exp;
        int lat;
        int busy_hi;
        in_valid = 1'b1; in_data = din; state_clr = clr_acc;
        if (coef_acc) begin coef_we = 1'b1; coef_addr = ca; coef_wdata = cd; end
        @(posedge clk); #1;
        in_valid = 1'b0; state_clr = 1'b0; coef_we = 1'b0; in_data = $urandom;
        if (clr_acc) model_clear();
        if (coef_acc) model_write(ca, cd);
        model_frame(din, exp);
        if (clr_mid) model_clear();
        lat = 0; busy_hi = 0;
        if (in_ready) busy_hi++;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                state_clr = clr_mid;
                if (coef_mid) begin coef_we = 1'b1; coef_addr = ca; coef_wdata = cd; end
            end
            if (n == 11) begin state_clr = 1'b0; coef_we = 1'b0; end
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
            if (in_ready) busy_hi++;
        end
        state_clr = 1'b0; coef_we = 1'b0;
        check("latency", 64'(lat), 64'd25);
        check("busy_ready", 64'(busy_hi), 64'd0);
        got = out_data;
        check("out_ch0", 64'(out_data[15:0]), 64'(exp[15:0]));
        check("out_ch1", 64'(out_data[31:16]), 64'(exp[31:16]));
        check("ready_after", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("pulse_len", 64'(out_valid), 64'd0);
        check("out_held", 64'(out_data), 64'(exp));
    endtask

    task automatic frame(input logic [31:0] din, output logic [31:0] got);
        run_frame(din, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, got);
    endtask

    initial begin
        logic [31:0] got;
        logic [15:0] t_in  [4];
        logic [15:0] t2_ex [4];
        logic [15:0] t4_ex [4];
        int pulses;
        t_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
        t2_ex = '{16'h1000, 16'h1000, 16'h1000, 16'h0000};
        t4_ex = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; state_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_coef_ready", 64'(coef_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        // identity pass-through
        frame(32'h8000_1234, got);
        check("t1_identity", 64'(got), 64'h8000_1234);

        // FIR taps of 0.25 on section 0
        clr_idle();
        for (int i = 0; i < 3; i++) write_coef(0, i, 24'h080000);
        for (int i = 0; i < 4; i++) begin
            frame({16'h0000, t_in[i]}, got);
            check("t2_fir_ch0", 64'(got[15:0]), 64'(t2_ex[i]));
            check("t2_ch1", 64'(got[31:16]), 64'd0);
        end
        write_coef(0, 1, 24'h0); write_coef(0, 2, 24'h0); write_coef(0, 0, 24'h200000);

        // saturation with gain 2.0
        write_coef(0, 0, 24'h400000);
        frame(32'h0000_6000, got);
        check("t3_sat_pos", 64'(got[15:0]), 64'h7FFF);
        frame(32'h0000_A000, got);
        check("t3_sat_neg", 64'(got[15:0]), 64'h8000);
        write_coef(0, 0, 24'h200000);

        // one-pole decay, then state_clr while busy and at acceptance
        clr_idle();
        write_coef(0, 3, 24'hF00000);
        for (int i = 0; i < 4; i++) begin
            frame({16'h0000, t_in[i]}, got);
            check("t4_decay", 64'(got[15:0]), 64'(t4_ex[i]));
        end
        run_frame(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 24'h0, got);
        check("t4_clr_busy_frame", 64'(got[15:0]), 64'h0400);
        frame(32'h0, got);
        check("t4_after_clr", 64'(got[15:0]), 64'h0000);
        frame(32'h0000_4000, got);
        run_frame(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, got);
        check("t4_clr_accept", 64'(got[15:0]), 64'h0000);
        write_coef(0, 3, 24'h0);

        // coefficient write while busy is dropped; at acceptance it applies
        run_frame(32'h1111_2000, 1'b0, 1'b0, 1'b0, 1'b1, caddr(0, 0), 24'h100000, got);
        frame(32'h0000_2000, got);
        check("t5_busy_write_dropped", 64'(got[15:0]), 64'h2000);
        run_frame(32'h0000_2000, 1'b0, 1'b0, 1'b1, 1'b0, caddr(0, 0), 24'h100000, got);
        check("t5_accept_write", 64'(got[15:0]), 64'h1000);

        // reset mid-frame
        in_valid = 1'b1; in_data = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("t6_ready", 64'(in_ready), 64'd1);
        check("t6_out_data", 64'(out_data), 64'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("t6_no_pulse", 64'(pulses), 64'd0);
        frame(32'h9ABC_0123, got);
        check("t6_identity", 64'(got), 64'h9ABC_0123);

        // random coefficients, data and clears
        write_coef(1, 6, 24'($urandom));
        for (int s = 0; s < SEC; s++)
            for (int i = 0; i < 5; i++) write_coef(s, i, 24'($urandom) >>> ($urandom_range(0, 3)));
        for (int f = 0; f < 20; f++)
            run_frame($urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      1'b0, 1'b0, 4'h0, 24'h0, got);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
